fetch_pc_predictor: RTL
=======================

Name: fetch_pc_predictor

Overview:
Parametrised fetch-stage PC generator. Successor to the basic PC register + 4 / branch-target mux. Adds the following:
- a stall hold,
- an EX-stage redirect for mispredict correction,
- a configurable reset vector,
- a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches can be followed without a bubble.

It sits in the IF stage. It drives the instruction-memory address and sends the prediction down the pipe, so EX can detect mispredicts.

Parameters:
XLEN, 32, address/PC width in bits.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
BTB_ENTRIES, 16, number of BTB entries; must be a power of 2 and at least 2. IDX = log2(BTB_ENTRIES).
BTB_EN, 1, 0 disables prediction: pred_taken_f is forced to 0 and updates are ignored.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
stall_f  input  1  hold pc_f (hazard unit load-use stall).
redirect_e  input  1  EX found a mispredict; fetch must restart at redirect_pc_e.
redirect_pc_e  input  XLEN  absolute correct next PC (not an offset).
upd_valid_e  input  1  a branch/jump resolved in EX this cycle; train the BTB.
upd_pc_e  input  XLEN  PC of the resolved branch.
upd_taken_e  input  1  actual branch outcome.
upd_target_e  input  XLEN  actual absolute branch target.
pc_f  output  XLEN  current fetch PC (registered).
pred_taken_f  output  1  BTB predicts pc_f is a taken branch (combinational from pc_f).
pred_target_f  output  XLEN  predicted next PC: BTB target if pred_taken_f, else pc_f+4.

Behaviour:
- Reset (rst=1 at edge):
  - pc_f <= RESET_VECTOR.
  - All BTB valid bits cleared; all counters set to 0.
  - rst overrides every other input, including a reset asserted mid-stall or mid-redirect.
- Next-PC priority at each edge, highest first:
  1. rst
  2. redirect_e -> redirect_pc_e; this overrides stall_f.
  3. stall_f -> hold pc_f.
  4. otherwise -> pred_target_f.
- Latency: a redirect takes effect the cycle after redirect_e is asserted. pc_f is never combinationally affected by inputs.
- Arithmetic: pc_f+4 is computed modulo 2^XLEN. 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
- BTB entry fields: valid, tag = pc[XLEN-1:IDX+2], target[XLEN-1:0], ctr[1:0]. pc[1:0] is ignored.
- Lookup index = pc_f[IDX+1:2]. Hit = valid && tag match.
- pred_taken_f = BTB_EN && hit && ctr[1].
- Update (upd_valid_e, BTB_EN=1), index/tag from upd_pc_e:
  - Hit, taken: ctr <= sat_inc(ctr); target <= upd_target_e.
  - Hit, not taken: ctr <= sat_dec(ctr); target unchanged.
  - Miss, taken: allocate; valid <= 1, tag written, target <= upd_target_e, ctr <= 2'b10 (weakly taken). Replaces any aliasing entry.
  - Miss, not taken: no change.
  - Counter saturates at 3 and at 0.
- Update and lookup to the same index in the same cycle: the lookup sees pre-update contents. The write is visible from the next cycle (no bypass).
- Update is independent of stall_f and redirect_e. It happens whenever upd_valid_e=1 and rst=0.
- Update while rst=1 is discarded.
- BTB_EN=0: the BTB array may be optimised away; pred_target_f = pc_f+4.

Test Plan:
- Reset/sequential: RESET_VECTOR=0x100, rst for 2 cycles, then idle -> pc_f 0x100, 0x104, 0x108; pred_taken_f=0 throughout.
- Stall vs redirect: stall_f=1 at pc_f=0x20 for 3 cycles -> pc_f stays 0x20. Assert redirect_e with redirect_pc_e=0x80 while stall_f=1 -> next pc_f=0x80.
- BTB train/predict: upd_valid_e with upd_pc_e=0x10, taken, target 0x40. Later fetch reaches 0x10 -> pred_taken_f=1, pred_target_f=0x40, next pc_f=0x40 with no bubble.
- Counter hysteresis:
  - After the allocate above (ctr=2), one not-taken update on 0x10 -> ctr=1, predict 0x14.
  - One taken update -> ctr=2, predict 0x40 again.
  - Three taken updates -> ctr saturates at 3.
  - One not-taken update -> ctr=2, still predicts taken.
- Aliasing: BTB_ENTRIES=16, entry allocated for 0x10. Fetch 0x50 (same index, different tag) -> pred_taken_f=0, pred_target_f=0x54.
- Edges:
  - pc_f=0xFFFF_FFFC, no hit -> next pc_f=0x0.
  - Same-cycle update and lookup at 0x10 -> the old prediction is used that cycle and the new one from the next.
  - rst during redirect_e -> pc_f=RESET_VECTOR and BTB invalidated.

Source files
------------

// File: rtl/fetch_pc_predictor.sv
// IF-stage PC generator: registered fetch PC with stall, EX redirect and a
// direct-mapped BTB of 2-bit saturating counters for zero-bubble taken branches.
module fetch_pc_predictor #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     BTB_ENTRIES  = 16,
    parameter int unsigned     BTB_EN       = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            redirect_e,
    input  logic [XLEN-1:0] redirect_pc_e,
    input  logic            upd_valid_e,
    input  logic [XLEN-1:0] upd_pc_e,
    input  logic            upd_taken_e,
    input  logic [XLEN-1:0] upd_target_e,
    output logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] pred_target_f
);

    localparam int unsigned IDX = $clog2(BTB_ENTRIES);
    localparam int unsigned TW  = XLEN - IDX - 2;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;

    logic            valid_q  [BTB_ENTRIES];
    logic [TW-1:0]   tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0] target_q [BTB_ENTRIES];
    logic [1:0]      ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0]  lk_idx;
    logic [TW-1:0]   lk_tag;
    logic            lk_hit;
    logic [IDX-1:0]  up_idx;
    logic [TW-1:0]   up_tag;
    logic            up_hit;

    // pc[1:0] never takes part in index or tag.
    assign lk_idx = pc_q[IDX+1:2];
    assign lk_tag = pc_q[XLEN-1:IDX+2];
    assign up_idx = upd_pc_e[IDX+1:2];
    assign up_tag = upd_pc_e[XLEN-1:IDX+2];

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        pc_plus4      = pc_q + XLEN'(4);
        pred_taken_f  = (BTB_EN != 0) && lk_hit && ctr_q[lk_idx][1];
        pred_target_f = pred_taken_f ? target_q[lk_idx] : pc_plus4;
    end

    assign pc_f = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else if (redirect_e) begin
            pc_q <= redirect_pc_e;
        end else if (!stall_f) begin
            pc_q <= pred_target_f;
        end
    end

    // Lookup above reads pre-edge contents, so a same-cycle write is seen next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
        end else if ((BTB_EN != 0) && upd_valid_e) begin
            if (up_hit) begin
                if (upd_taken_e) begin
                    ctr_q[up_idx]    <= (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
                    target_q[up_idx] <= upd_target_e;
                end else begin
                    ctr_q[up_idx] <= (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken_e) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target_e;
                ctr_q[up_idx]    <= 2'b10;
            end
        end
    end

endmodule
